// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter that lets NREQ requesters share one
// SPI master byte port. It runs one byte exchange at a time: launch, wait for
// the receive strobe (or time out), then return the byte to the owner.
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic                 data_send_enable,
  output logic [DW-1:0]        data_send_master,
  input  logic [DW-1:0]        data_receive_master,
  input  logic                 data_receive_master_enable
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic [DW-1:0] tx_byte;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  int            cand;
  logic [IW-1:0] ptr_next;

  // Round-robin search: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    cand       = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  // The pointer moves to the requester just after the one served.
  assign ptr_next = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);

  // Transaction FSM plus the response registers it fills in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      idx         <= '0;
      timer       <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            idx   <= pick_idx;
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A strobe on the last budgeted cycle still wins over the timeout.
          if (data_receive_master_enable) begin
            rsp_data    <= data_receive_master;
            rsp_timeout <= 1'b0;
            state       <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            state       <= S_RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RESP: begin
          ptr   <= ptr_next;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture the winner's byte at selection; later req_data changes are ignored.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && pick_found) begin
      tx_byte <= req_data[int'(pick_idx)*DW +: DW];
    end
  end

  assign busy             = (state != S_IDLE);
  assign data_send_enable = (state == S_LAUNCH);
  assign data_send_master = data_send_enable ? tx_byte : '0;

  // Grant covers LAUNCH through RESP; the completion pulse is RESP only.
  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i]       = busy && (idx == IW'(i));
      rsp_valid[i] = (state == S_RESP) && (idx == IW'(i));
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Testbench for spi_txn_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level round-robin / SPI-response model.
module tb_spi_txn_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = TIMEOUT + 100;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                rsp_timeout;
  logic                busy;
  logic                data_send_enable;
  logic [DW-1:0]       data_send_master;
  logic [DW-1:0]       data_receive_master;
  logic                data_receive_master_enable;

  int n_chk  = 0;
  int n_fail = 0;
  int m_ptr  = 0;
  logic [DW-1:0] mdata [NREQ];
  int served;

  spi_txn_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .req                        (req),
    .req_data                   (req_data),
    .gnt                        (gnt),
    .rsp_valid                  (rsp_valid),
    .rsp_data                   (rsp_data),
    .rsp_timeout                (rsp_timeout),
    .busy                       (busy),
    .data_send_enable           (data_send_enable),
    .data_send_master           (data_send_master),
    .data_receive_master        (data_receive_master),
    .data_receive_master_enable (data_receive_master_enable)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first requester at or after p, modulo NREQ.
  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_data[i*DW +: DW] = d;
    mdata[i] = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"},   gnt, '0);
    check_eq({tag, "_rspv"},  rsp_valid, '0);
    check_eq({tag, "_rspd"},  rsp_data, '0);
    check_eq({tag, "_rspto"}, rsp_timeout, 0);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_dse"},   data_send_enable, 0);
    check_eq({tag, "_dsm"},   data_send_master, '0);
  endtask

  // One transaction with the current req mask. t_strobe is the WAIT-cycle
  // offset (0 = first WAIT cycle) at which the SPI model strobes rx; values
  // >= TIMEOUT mean the strobe never comes in time. noise adds ignored
  // strobes outside WAIT and drops the winner's req mid-transaction.
  task automatic run_txn(input int t_strobe, input logic [DW-1:0] rx, input bit noise,
                         output int srv);
    int w, lat, exp_lat, extra;
    bit got;
    w   = rr_pick(req, m_ptr);
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (data_send_enable) got = 1'b1;
      else begin
        data_receive_master_enable = noise;
        data_receive_master        = DW'($urandom);
      end
    end
    check_eq("launch_seen", got, 1);
    if (!got || w < 0) begin
      srv = -1;
      return;
    end
    check_eq("launch_gnt",  gnt, 32'(1) << w);
    check_eq("launch_byte", data_send_master, mdata[w]);
    check_eq("launch_busy", busy, 1);
    // Strobe during LAUNCH must be ignored.
    data_receive_master_enable = noise;
    data_receive_master        = DW'($urandom);
    exp_lat = (t_strobe < TIMEOUT) ? t_strobe + 2 : TIMEOUT + 1;
    lat   = -1;
    extra = 0;
    for (int n = 1; n <= TIMEOUT + 8 && lat < 0; n++) begin
      @(negedge clk);
      if (data_send_enable) extra++;
      if (rsp_valid != '0) lat = n;
      else begin
        if (n == 1) check_eq("wait_gnt", gnt, 32'(1) << w);
        data_receive_master_enable = (n == t_strobe + 1);
        data_receive_master        = (n == t_strobe + 1) ? rx : DW'($urandom);
        if (n == 1 && noise) req[w] = 1'b0;
      end
    end
    check_eq("rsp_latency", lat, exp_lat);
    check_eq("rsp_valid",   rsp_valid, 32'(1) << w);
    check_eq("rsp_data",    rsp_data, (t_strobe < TIMEOUT) ? rx : '0);
    check_eq("rsp_timeout", rsp_timeout, (t_strobe < TIMEOUT) ? 0 : 1);
    check_eq("rsp_gnt",     gnt, 32'(1) << w);
    check_eq("no_relaunch", extra, 0);
    // Strobe during RESP must be ignored; owner clears req on this edge.
    data_receive_master_enable = noise;
    data_receive_master        = DW'($urandom);
    req[w] = 1'b0;
    m_ptr  = (w + 1) % NREQ;
    srv    = w;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    data_receive_master_enable = 1'b0;
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_gnt"},  gnt, '0);
    check_eq({tag, "_dse"},  data_send_enable, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    data_receive_master_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  initial begin
    req = '0;
    req_data = '0;
    data_receive_master = '0;
    data_receive_master_enable = 1'b0;
    for (int i = 0; i < NREQ; i++) mdata[i] = '0;
    do_reset();
    check_reset_outputs("por");

    // Single request: strobe 18 cycles after launch.
    set_req(0, 8'hd3);
    run_txn(17, 8'hc2, 1'b0, served);
    check_eq("single_srv", served, 0);
    expect_idle("single_idle");

    // Simultaneous requesters 1 and 3 from ptr=0.
    do_reset();
    set_req(1, 8'ha9);
    set_req(3, 8'h35);
    run_txn(5, 8'h11, 1'b0, served);
    check_eq("simul_first", served, 1);
    run_txn(9, 8'h22, 1'b0, served);
    check_eq("simul_second", served, 3);
    expect_idle("simul_idle");

    // Fairness: all requesters held continuously.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, DW'(8'h40 + i));
    for (int k = 0; k < 8; k++) begin
      run_txn(int'($urandom_range(0, 6)), DW'($urandom), 1'b0, served);
      check_eq("fair_order", served, k % NREQ);
      if (served >= 0) req[served] = 1'b1;
    end
    req = '0;
    expect_idle("fair_idle");
    expect_idle("fair_idle2");

    // Timeout on requester 2, then ptr must sit at 3.
    do_reset();
    set_req(2, 8'h77);
    run_txn(NEVER, 8'hee, 1'b0, served);
    expect_idle("to_idle");
    set_req(0, 8'h01);
    set_req(3, 8'h03);
    run_txn(3, 8'h5c, 1'b0, served);
    check_eq("to_ptr_adv", served, 3);
    req = '0;
    expect_idle("to_idle2");

    // Strobe on the last budgeted WAIT cycle, and one cycle too late.
    set_req(1, 8'h9e);
    run_txn(TIMEOUT - 1, 8'hb7, 1'b0, served);
    expect_idle("bnd_idle");
    set_req(1, 8'h9f);
    run_txn(TIMEOUT, 8'hb8, 1'b0, served);
    expect_idle("bnd_idle2");

    // Reset mid-transaction with ptr != 0, then a late strobe.
    set_req(1, 8'h10);
    run_txn(2, 8'hab, 1'b0, served);
    expect_idle("pre_rst_idle");
    set_req(2, 8'h5a);
    for (int c = 0; c < 6; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst   = 1'b0;
    req   = '0;
    m_ptr = 0;
    data_receive_master_enable = 1'b1;
    data_receive_master        = 8'h77;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      data_receive_master_enable = 1'b0;
      check_eq("late_strobe_rspv", rsp_valid, '0);
      check_eq("late_strobe_busy", busy, 0);
    end
    set_req(0, 8'hc0);
    set_req(3, 8'hc3);
    run_txn(4, 8'h66, 1'b0, served);
    check_eq("post_rst_ptr0", served, 0);
    req = '0;
    expect_idle("post_rst_idle");

    // Randomized traffic.
    for (int k = 0; k < 30; k++) begin
      logic [NREQ-1:0] add;
      int ts;
      add = NREQ'($urandom);
      if (req == '0 && add == '0) add = NREQ'(1) << $urandom_range(0, NREQ - 1);
      for (int i = 0; i < NREQ; i++) begin
        if (add[i] && !req[i]) set_req(i, DW'($urandom));
      end
      ts = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 3))
                                       : int'($urandom_range(0, 20));
      run_txn(ts, DW'($urandom), 1'($urandom), served);
    end
    req = '0;
    expect_idle("rand_idle");
    expect_idle("rand_idle2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
